// File: rtl/frame_serializer_if.sv
// Purpose  : handshake/bus bundle between a payload source and frame_serializer.
// Latency  : n/a (wires only).
// Backpress: source must hold start until busy rises; start is ignored while busy.
// Ports    : Clk_EN/start/data_in driven by master; serOut/serOutValid/busy/done by slave.
interface frame_serializer_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    Clk_EN;       // bit-rate enable
   logic                    start;        // frame request
   logic [PAYLOAD_BITS-1:0] data_in;      // payload, captured on accept
   logic                    serOut;       // serial line
   logic                    serOutValid;  // frame on the line
   logic                    busy;         // accept .. frame complete
   logic                    done;         // one-clk pulse at frame end

   modport master (
      output Clk_EN, start, data_in,
      input  serOut, serOutValid, busy, done
   );

   modport slave (
      input  Clk_EN, start, data_in,
      output serOut, serOutValid, busy, done
   );
endinterface

// File: rtl/frame_serializer.sv
// Purpose  : serialises a payload word as header 110101, gap 0, payload MSB-first, guard 0s.
// Latency  : first header bit on the line the cycle after accept; done 7+PAYLOAD+GUARD enabled edges later.
// Backpress: one frame in flight; start is ignored while busy, accepted again the edge after done.
// Ports    : clk, rst (async active-high); bus = frame_serializer_if.slave
//            (Clk_EN, start, data_in in; serOut, serOutValid, busy, done out).
module frame_serializer #(
   parameter int PAYLOAD_BITS = 8,
   parameter int GUARD_BITS   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   frame_serializer_if.slave        bus
);

   // Counter must span the longest field (header is 6 bits).
   localparam int M1 = (PAYLOAD_BITS > 6) ? PAYLOAD_BITS : 6;
   localparam int M2 = (GUARD_BITS > M1) ? GUARD_BITS : M1;
   localparam int CW = $clog2(M2 + 1);

   localparam logic [CW-1:0] HDR_LAST   = CW'(5);
   localparam logic [CW-1:0] DATA_LAST  = CW'(PAYLOAD_BITS - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_BITS - 1);

   // Header bits indexed by counter: bit0 is sent first (1,1,0,1,0,1).
   localparam logic [7:0] HDR_PAT = 8'b0010_1011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_GAP,
      S_DATA,
      S_GUARD
   } state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [PAYLOAD_BITS-1:0] shreg_q;
   logic                    ser_q;
   logic                    vld_q;
   logic                    busy_q;
   logic                    done_q;

   logic [CW-1:0]           cnt_plus1;
   logic [PAYLOAD_BITS-1:0] shreg_shl;

   assign cnt_plus1 = cnt_q + 1'b1;
   assign shreg_shl = shreg_q << 1;

   // Line outputs are registered alongside the state so they reflect the
   // bit for the state being entered; they never depend on inputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         ser_q   <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Accept ignores Clk_EN so a request is never missed.
               if (bus.start) begin
                  shreg_q <= bus.data_in;
                  busy_q  <= 1'b1;
                  vld_q   <= 1'b1;
                  cnt_q   <= '0;
                  ser_q   <= HDR_PAT[0];
                  state_q <= S_HDR;
               end
            end
            S_HDR: begin
               if (bus.Clk_EN) begin
                  if (cnt_q == HDR_LAST) begin
                     cnt_q   <= '0;
                     ser_q   <= 1'b0;
                     state_q <= S_GAP;
                  end else begin
                     cnt_q <= cnt_plus1;
                     ser_q <= HDR_PAT[cnt_plus1[2:0]];
                  end
               end
            end
            S_GAP: begin
               if (bus.Clk_EN) begin
                  cnt_q   <= '0;
                  ser_q   <= shreg_q[PAYLOAD_BITS-1];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bus.Clk_EN) begin
                  shreg_q <= shreg_shl;
                  if (cnt_q == DATA_LAST) begin
                     cnt_q   <= '0;
                     ser_q   <= 1'b0;
                     state_q <= S_GUARD;
                  end else begin
                     cnt_q <= cnt_plus1;
                     ser_q <= shreg_shl[PAYLOAD_BITS-1];
                  end
               end
            end
            S_GUARD: begin
               if (bus.Clk_EN) begin
                  ser_q <= 1'b0;
                  if (cnt_q == GUARD_LAST) begin
                     cnt_q   <= '0;
                     vld_q   <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_plus1;
                  end
               end
            end
            default: begin
               cnt_q   <= '0;
               ser_q   <= 1'b0;
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.serOut      = ser_q;
   assign bus.serOutValid = vld_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule
